// File: rtl/duty_slew_pkg.sv
// Shared types and arithmetic helpers for the duty-cycle slew limiter.
package duty_slew_pkg;

   localparam int unsigned DUTY_W = 10;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SOFTSTART = 2'd1,
      ST_TRACK     = 2'd2,
      ST_FAULT     = 2'd3
   } state_e;

   function automatic duty_t clamp_duty(input duty_t d, input duty_t lo, input duty_t hi);
      if (d < lo) return lo;
      if (d > hi) return hi;
      return d;
   endfunction

   // One slew step toward tgt; the difference is signed W+1 bits so nothing wraps.
   function automatic duty_t slew_step(input duty_t cur, input duty_t tgt, input duty_t step);
      logic signed [DUTY_W:0] diff;
      logic signed [DUTY_W:0] lim;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      lim  = $signed({1'b0, step});
      if (diff > lim)  return cur + step;
      if (diff < -lim) return cur - step;
      return tgt;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; rise_c is high in the first cycle sig_i is sampled high.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic rise_c
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (!rst_n) sig_q <= 1'b0;
      else        sig_q <= sig_i;
   end

   assign rise_c = sig_i & ~sig_q;

endmodule

// File: rtl/duty_slew_limiter.sv
// Clamps duty commands and slews d_out toward them on control-period ticks,
// with soft-start after enable and a latched fault shutdown.
module duty_slew_limiter
   import duty_slew_pkg::*;
#(
   parameter int unsigned W       = DUTY_W,
   parameter int unsigned D_MIN   = 20,
   parameter int unsigned D_MAX   = 980,
   parameter int unsigned STEP    = 16,
   parameter int unsigned SS_STEP = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic         tick_in,
   input  logic [W-1:0] d_target,
   input  logic         d_valid,
   input  logic         fault,
   output logic [W-1:0] d_out,
   output logic [1:0]   state_o,
   output logic         at_target,
   output logic         fault_latched
);

   localparam duty_t DMIN_C    = W'(D_MIN);
   localparam duty_t DMAX_C    = W'(D_MAX);
   localparam duty_t STEP_C    = W'(STEP);
   localparam duty_t SSSTEP_C  = W'(SS_STEP);

   logic   tick_rise;
   state_e state_q, state_d;
   duty_t  d_out_q, d_out_d;
   duty_t  target_q, target_d;
   logic   at_target_q, at_target_d;
   logic   fault_latched_q, fault_latched_d;

   rise_detect u_tick_rise (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (tick_in),
      .rise_c (tick_rise)
   );

   // Next-state logic: fault has priority over enable, enable over tick.
   always_comb begin
      state_d  = state_q;
      d_out_d  = d_out_q;
      target_d = d_valid ? clamp_duty(d_target, DMIN_C, DMAX_C) : target_q;

      if (fault) begin
         state_d = ST_FAULT;
         d_out_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               d_out_d = '0;
               if (ce) state_d = ST_SOFTSTART;
            end
            ST_SOFTSTART: begin
               if (!ce) begin
                  state_d = ST_IDLE;
                  d_out_d = '0;
               end else if (tick_rise) begin
                  // The step uses the target held before any same-cycle capture.
                  d_out_d = slew_step(d_out_q, target_q, SSSTEP_C);
                  if (d_out_d == target_q) state_d = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (!ce) begin
                  state_d = ST_IDLE;
                  d_out_d = '0;
               end else if (tick_rise) begin
                  d_out_d = slew_step(d_out_q, target_q, STEP_C);
               end
            end
            ST_FAULT: begin
               d_out_d = '0;
               if (!ce) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               d_out_d = '0;
            end
         endcase
      end

      at_target_d     = ((state_d == ST_SOFTSTART) || (state_d == ST_TRACK)) &&
                        (d_out_d == target_d);
      fault_latched_d = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         d_out_q         <= '0;
         target_q        <= DMIN_C;
         at_target_q     <= 1'b0;
         fault_latched_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         d_out_q         <= d_out_d;
         target_q        <= target_d;
         at_target_q     <= at_target_d;
         fault_latched_q <= fault_latched_d;
      end
   end

   assign d_out         = d_out_q;
   assign state_o       = state_q;
   assign at_target     = at_target_q;
   assign fault_latched = fault_latched_q;

endmodule

// File: doc/duty_slew_limiter.md
Name: duty_slew_limiter

Overview:
- Upstream stage of the half-bridge PWM. Accepts duty commands from the control processor and produces the 10-bit duty word that drives d_halfbridge.
- Applies the changes only on control-period ticks, derived from the rising edge of clk_int (50 us).
- Clamps each command to a safe window and slew-limits every change.
- Provides soft-start after enable and a latched fault shutdown that forces the duty to zero.

Parameters:
W, 10, duty word width (matches d_halfbridge)
D_MIN, 20, lowest clamped target duty
D_MAX, 980, highest clamped target duty (D_MIN <= D_MAX < 2**W)
STEP, 16, max duty change per tick in TRACK
SS_STEP, 4, max duty change per tick in SOFTSTART

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  synchronous active-low reset
ce  in  1  converter enable
tick_in  in  1  control-period square wave (clk_int), same clock domain
d_target  in  W  commanded duty
d_valid  in  1  one-cycle strobe; capture d_target
fault  in  1  hardware fault request, level
d_out  out  W  slewed duty to the half-bridge PWM
state_o  out  2  current state encoding (IDLE=0, SOFTSTART=1, TRACK=2, FAULT=3)
at_target  out  1  d_out == clamped target
fault_latched  out  1  high while in FAULT

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 on a clk edge, all registers clear:
  - d_out=0, target register=D_MIN, tick_q=0
  - state=IDLE, at_target=0, fault_latched=0
- Tick detection:
  - tick_rise = tick_in & ~tick_q, where tick_q is the registered tick_in.
  - A duty update lands on the same clk edge that first samples tick_in=1, so d_out changes at that edge.
- Target capture:
  - On a d_valid cycle, the target register loads clamp(d_target, D_MIN, D_MAX); this is accepted in every state.
  - If d_valid and tick_rise occur in the same cycle, the step uses the OLD target; the new one applies from the next tick.
- Slew step on tick_rise:
  - diff = target - d_out, computed signed in W+1 bits.
  - If |diff| <= S, d_out = target; otherwise d_out moves by S toward the target.
  - S=SS_STEP in SOFTSTART, S=STEP in TRACK.
  - No wrap-around: intermediate sums are W+1 bits, and the result always lies between the old d_out and the target.
- State machine (evaluated every clk; priority fault > ce > tick):
  - IDLE: d_out held 0. If ce=1 and fault=0, go to SOFTSTART.
  - SOFTSTART: d_out ramps from 0 with SS_STEP. When a tick makes d_out == target, go to TRACK on that same edge.
  - TRACK: d_out follows target with STEP. A new target mid-slew simply redirects the slew, with no state change.
  - Any non-FAULT state: ce=0 forces IDLE and d_out=0 at the next edge, whether mid-ramp or not.
  - Any state: fault=1 forces FAULT and d_out=0 at the next edge, and sets fault_latched=1.
  - FAULT: d_out held 0. Exit to IDLE only when fault=0 AND ce=0; re-enable then requires ce going high again (a fresh soft-start).
- at_target: registered; 1 when state is SOFTSTART or TRACK and d_out == target.
- d_out below D_MIN is permitted only transiently during SOFTSTART ramp-up and in IDLE/FAULT (value 0).
- ce=0 with tick_rise: tick is ignored.

Decomposition:
- Package duty_slew_pkg:
  - state enum (IDLE, SOFTSTART, TRACK, FAULT) with 2-bit encoding
  - DUTY_W=10
  - function clamp_duty
  - function slew_step(cur, tgt, step)
- Sub-module rise_detect: 1-bit registered rising-edge detector with synchronous active-low reset. Instantiated for tick_in; reusable for ce in the top.

Test Plan:
- Reset, then hold rst_n=0 for 3 clk with ce=1 and tick toggling -> d_out=0, state_o=0, fault_latched=0 throughout.
- d_target=500 with d_valid, then ce=1, 50 us ticks -> d_out = 4, 8, … 500 after exactly 125 ticks; state_o goes 1 -> 2 on the 125th tick; at_target=1.
- In TRACK at 500, command 300 -> d_out = 484, 468, … 308, then 300 on tick 13; between ticks d_out is stable.
- Command 1023 while at 960, then command 5 -> target clamps to 980 and d_out reaches 980 (two ticks: 976, 980); with 5 the target becomes 20 and d_out descends in 16-steps to 20, never below.
- Assert fault mid-ramp at d_out=200 -> d_out=0 next edge, state_o=3. Deassert fault with ce=1 -> remains FAULT. Drop ce -> IDLE. Raise ce -> SOFTSTART from 0.
- d_valid(700) in the same cycle as tick_rise while tracking at 600 with target 600 -> d_out stays 600 on that tick; next tick 616.
